weight_mac_seq: RTL

WEIGHT_MAC_SEQ -- requirements
Module: weight_mac_seq

---
 rtl/ann_pkg.sv | 24 ++
 rtl/q88_saturate.sv | 34 +++
 rtl/weight_mac_seq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ann_pkg.sv
// Shared defaults, accumulator sizing and FSM state type
// for the weight MAC datapath.
package ann_pkg;

  localparam int DW_D      = 16;
  localparam int AW_D      = 5;
  localparam int N_TERMS_D = 28;
  localparam int FRAC_D    = 8;

  // Six guard bits keep up to 32 full-scale products from wrapping
  function automatic int acc_width(input int dw);
    return 2 * dw + 6;
  endfunction

  localparam int ACC_W_D = acc_width(DW_D);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FINISH
  } mac_state_e;

endpackage

// File: rtl/q88_saturate.sv
// Rescales a wide fixed-point accumulator by FRAC and clamps
// it into a signed DW-bit result.
module q88_saturate
  import ann_pkg::*;
#(
  parameter int DW   = DW_D,
  parameter int FRAC = FRAC_D,
  parameter int ACCW = ACC_W_D
) (
  input  logic signed [ACCW-1:0] i_acc,
  output logic        [DW-1:0]   o_res
);

  logic signed [ACCW-1:0] w_sh;
  logic [ACCW-DW:0]       w_hi;
  logic                   w_pos;
  logic                   w_neg;

  assign w_sh  = i_acc >>> FRAC;
  assign w_hi  = w_sh[ACCW-1:DW-1];
  // Out of range when the bits above the result sign disagree
  assign w_pos = ~w_sh[ACCW-1] & (|w_hi);
  assign w_neg = w_sh[ACCW-1] & ~(&w_hi);

  always_comb begin
    o_res = w_sh[DW-1:0];
    if (w_pos) begin
      o_res = {1'b0, {(DW-1){1'b1}}};
    end else if (w_neg) begin
      o_res = {1'b1, {(DW-1){1'b0}}};
    end
  end

endmodule

// File: rtl/weight_mac_seq.sv
// Sequential dot product of streamed activations against
// BRAM weights, plus bias, with saturated Q8.8 result.
module weight_mac_seq
  import ann_pkg::*;
#(
  parameter int N_TERMS = N_TERMS_D,
  parameter int DW      = DW_D,
  parameter int AW      = AW_D,
  parameter int FRAC    = FRAC_D
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic [DW-1:0] BIAS,
  input  logic [DW-1:0] X_DATA,
  input  logic          X_VALID,
  output logic          X_READY,
  output logic [AW-1:0] W_ADDR,
  output logic          W_EN,
  output logic          W_WE,
  input  logic [DW-1:0] W_DO,
  output logic [DW-1:0] RESULT,
  output logic          DONE,
  output logic          BUSY
);

  localparam int ACCW = acc_width(DW);
  localparam int PW   = 2 * DW;
  localparam logic [AW-1:0] LAST = AW'(N_TERMS - 1);

  mac_state_e             r_state;
  logic [AW-1:0]          r_idx;
  logic signed [ACCW-1:0] r_acc;
  logic signed [PW-1:0]   r_prod;
  logic                   r_pvld;
  logic                   r_done;
  logic [DW-1:0]          r_result;

  logic                   w_accept;
  logic signed [PW-1:0]   w_xe;
  logic signed [PW-1:0]   w_we;
  logic signed [PW-1:0]   w_prod;
  logic signed [ACCW-1:0] w_prod_ext;
  logic signed [ACCW-1:0] w_bias_ext;
  logic signed [ACCW-1:0] w_bias_acc;
  logic [DW-1:0]          w_sat;

  assign X_READY  = (r_state == RUN);
  assign W_EN     = (r_state == RUN);
  assign W_WE     = 1'b0;
  assign W_ADDR   = r_idx;
  assign BUSY     = (r_state != IDLE);
  assign RESULT   = r_result;
  assign DONE     = r_done;
  assign w_accept = X_READY & X_VALID;

  assign w_xe   = {{DW{X_DATA[DW-1]}}, X_DATA};
  assign w_we   = {{DW{W_DO[DW-1]}}, W_DO};
  assign w_prod = w_xe * w_we;

  assign w_prod_ext = {{(ACCW-PW){r_prod[PW-1]}}, r_prod};
  assign w_bias_ext = {{(ACCW-DW){BIAS[DW-1]}}, BIAS};
  assign w_bias_acc = w_bias_ext <<< FRAC;

  q88_saturate #(
    .DW  (DW),
    .FRAC(FRAC),
    .ACCW(ACCW)
  ) u_sat (
    .i_acc(r_acc),
    .o_res(w_sat)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_acc    <= '0;
      r_prod   <= '0;
      r_pvld   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      r_pvld <= w_accept;
      if (w_accept) begin
        r_prod <= w_prod;
      end
      // Product lands one edge after its accept
      if (r_pvld) begin
        r_acc <= r_acc + w_prod_ext;
      end
      unique case (r_state)
        IDLE: begin
          if (START) begin
            r_state <= RUN;
            r_idx   <= '0;
            r_acc   <= w_bias_acc;
          end
        end
        RUN: begin
          if (w_accept) begin
            if (r_idx == LAST) begin
              r_state <= DRAIN;
            end else begin
              r_idx <= r_idx + AW'(1);
            end
          end
        end
        DRAIN: begin
          r_state <= FINISH;
        end
        FINISH: begin
          r_result <= w_sat;
          r_done   <= 1'b1;
          r_state  <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
